// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } uart_tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular byte FIFO with a separate level counter, sticky overflow and flush.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [UART_DATA_W-1:0] wr_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic                   ovf_clr_i,
  output logic [UART_DATA_W-1:0] rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ADDR_W:0]        level_o,
  output logic                   overflow_o
);

  localparam int LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic                   wr_acc, wr_drop, pop_ok;

  assign full_o     = (level_q == FULL_LVL);
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  // Full is judged on the current level, so a pop in the same cycle never frees room.
  assign wr_acc  = wr_en_i && !full_o && !flush_i;
  assign wr_drop = wr_en_i && full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      level_d = level_q + LVL_W'(wr_acc) - LVL_W'(pop_ok);
    end
    if (wr_drop)        overflow_d = 1'b1;
    else if (ovf_clr_i) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit front-end: FIFO plus launch/done handshake FSM.
// Optional UART_TX_FIFO_THRESH_EN adds a registered low-water flag (level <= thresh).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   flush,
  input  logic                   ovf_clr,
  input  logic                   tx_done,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  output logic                   busy
`ifdef UART_TX_FIFO_THRESH_EN
  ,
  input  logic [ADDR_W:0]        thresh,
  output logic                   low_water
`endif
);

  uart_tx_state_e         state_q, state_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   pop;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .pop_i      (pop),
    .flush_i    (flush),
    .ovf_clr_i  (ovf_clr),
    .rd_data_o  (fifo_rd_data),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .overflow_o (overflow)
  );

  // The byte is captured on the pop so it stays stable for the whole transfer.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !empty && !flush) begin
          state_d   = LOAD;
          pop       = 1'b1;
          tx_data_d = fifo_rd_data;
        end
      end
      LOAD:      state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_start = (state_q == LOAD);
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);

`ifdef UART_TX_FIFO_THRESH_EN
  logic low_water_q;

  always_ff @(posedge clk) begin
    if (rst) low_water_q <= 1'b1;
    else     low_water_q <= (level <= thresh);
  end

  assign low_water = low_water_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model plus directed scenarios.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int DONE_DLY = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, wr_en = 1'b0, flush = 1'b0, ovf_clr = 1'b0, tx_done = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_start, full, empty, overflow, busy;
  logic [7:0] tx_data;
  logic [4:0] level;
`ifdef UART_TX_FIFO_THRESH_EN
  logic [4:0] thresh = 5'd4;
  logic       low_water;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy)
`ifdef UART_TX_FIFO_THRESH_EN
    ,
    .thresh   (thresh),
    .low_water(low_water)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, sticky flag, and "sending" covering launch+wait.
  logic [7:0] mq[$];
  logic [7:0] m_data = 8'h00;
  bit m_ovf = 0, m_start = 0, m_send = 0, m_lw = 1;
  bit launch, ostart, osend, drop;
  int sz;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_start = 0; m_send = 0; m_data = 8'h00; m_lw = 1;
    end else begin
      sz = mq.size();
`ifdef UART_TX_FIFO_THRESH_EN
      m_lw = (sz <= int'(thresh));
`endif
      ostart  = m_start;
      osend   = m_send;
      launch  = !osend && en && sz != 0 && !flush;
      m_start = launch;
      if (launch) begin
        m_data = mq.pop_front();
        m_send = 1;
      end else if (osend && !ostart && tx_done) begin
        m_send = 0;
      end
      drop = !flush && wr_en && sz == DEPTH;
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (flush) mq.delete();
      else if (wr_en && !drop) mq.push_back(wr_data);
    end
    #1;
    chk("cmp_tx_start", tx_start, m_start);
    chk("cmp_tx_data", tx_data, m_data);
    chk("cmp_level", level, mq.size());
    chk("cmp_empty", empty, mq.size() == 0);
    chk("cmp_full", full, mq.size() == DEPTH);
    chk("cmp_overflow", overflow, m_ovf);
    chk("cmp_busy", busy, m_send);
`ifdef UART_TX_FIFO_THRESH_EN
    chk("cmp_low_water", low_water, m_lw);
`endif
  end

  // Transmitter stand-in and start logger.
  logic [7:0] sent[$];
  int starts = 0;
  int cd = 0;
  bit auto_done = 0;

  task automatic tick();
    @(posedge clk);
    #2;
    tx_done = 1'b0;
    if (auto_done) begin
      if (tx_start) cd = DONE_DLY;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end
    end
    if (tx_start) begin
      starts++;
      sent.push_back(tx_data);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef UART_TX_FIFO_THRESH_EN
    chk({tag, "_low_water"}, low_water, 1);
`endif
  endtask

  int s0;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    en = 1'b1;
    tick();

    // Single byte latency
    wr(8'hA5);
    chk("t1_empty", empty, 0);
    chk("t1_no_start_yet", tx_start, 0);
    tick();
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_level", level, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_start_pulse", tx_start, 0);
    repeat (3) tick();
    chk("t1_busy_wait", busy, 1);
    tx_done = 1'b1;
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_starts", starts, 1);

    // Fill, overflow, then drain in order
    en = 1'b0;
    for (int i = 1; i <= 16; i++) wr(8'(i));
    chk("t2_full", full, 1);
    chk("t2_level", level, 16);
    chk("t2_no_start", starts, 1);
    wr(8'hFF);
    chk("t2_overflow", overflow, 1);
    chk("t2_level_kept", level, 16);
    sent.delete();
    starts = 0;
    en = 1'b1;
    auto_done = 1;
    repeat (200) tick();
    auto_done = 0;
    chk("t2_starts", starts, 16);
    for (int i = 0; i < 16; i++) begin
      if (i < sent.size()) chk("t2_order", sent[i], 8'(i + 1));
      else chk("t2_order_missing", i, 16);
    end
    chk("t2_empty", empty, 1);
    chk("t2_busy", busy, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", overflow, 0);

    // Full FIFO: pop, dropped write and overflow clear in one cycle
    en = 1'b0;
    for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
    en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h77;
    ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    chk("t3_level", level, 15);
    chk("t3_overflow", overflow, 1);
    chk("t3_start", tx_start, 1);
    chk("t3_data", tx_data, 8'h20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_flush_level", level, 0);
    chk("t3_busy", busy, 1);
    tx_done = 1'b1;
    tick();
    chk("t3_idle", busy, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Back-to-back: next start two cycles after done
    en = 1'b0;
    wr(8'h55);
    wr(8'hAA);
    en = 1'b1;
    tick();
    chk("t4_start1", tx_start, 1);
    chk("t4_data1", tx_data, 8'h55);
    tick();
    tx_done = 1'b1;
    tick();
    chk("t4_gap_start", tx_start, 0);
    chk("t4_gap_busy", busy, 0);
    tick();
    chk("t4_start2", tx_start, 1);
    chk("t4_data2", tx_data, 8'hAA);
    tick();
    tx_done = 1'b1;
    tick();
    chk("t4_idle", busy, 0);

    // Flush while a byte is in flight
    en = 1'b0;
    for (int i = 0; i < 6; i++) wr(8'(8'h60 + i));
    en = 1'b1;
    tick();
    tick();
    chk("t5_level_pre", level, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_level", level, 0);
    chk("t5_busy", busy, 1);
    chk("t5_data", tx_data, 8'h60);
    s0 = starts;
    repeat (4) tick();
    chk("t5_still_busy", busy, 1);
    tx_done = 1'b1;
    tick();
    repeat (5) tick();
    chk("t5_no_start", starts, s0);
    chk("t5_idle", busy, 0);
    chk("t5_data_hold", tx_data, 8'h60);

    // Reset in the middle of a transfer
    en = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'(8'h70 + i));
    en = 1'b1;
    tick();
    tick();
    chk("t6_level_pre", level, 3);
    rst = 1'b1;
    tick();
    chk_reset_vals("t6");
    rst = 1'b0;
    s0 = starts;
    repeat (5) tick();
    chk("t6_no_start", starts, s0);
    chk("t6_empty", empty, 1);

`ifdef UART_TX_FIFO_THRESH_EN
    // Low-water flag follows level one cycle late
    en = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'(8'h80 + i));
    tick();
    chk("t7_lw_high_level", low_water, 0);
    en = 1'b1;
    tick();
    chk("t7_level4", level, 4);
    chk("t7_lw_lag", low_water, 0);
    tick();
    chk("t7_lw_set", low_water, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tx_done = 1'b1;
    tick();
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
